aes_enc_seq: RTL

- Iterative AES encryption controller/datapath. Sequences one shared round unit over Nr rounds: 10, 12 or 14, selected per block at runtime by key length.
- Replaces the fully unrolled combinational encryptor where area matters.
- Round keys are read from an external round-key store, filled by a separate key-expansion block, through a combinational read port.
- Block in/out use valid/ready handshakes.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_round.sv | 50 +++++
 rtl/aes_enc_seq.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts, FSM encoding,
// S-box lookup and GF(2^8) doubling.
package aes_pkg;

    localparam logic [1:0] KL_128 = 2'd0;
    localparam logic [1:0] KL_192 = 2'd1;
    localparam logic [1:0] KL_256 = 2'd2;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Forward S-box, entry b occupies bits 8b..8b+7 (entry 0 leftmost).
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round count for a key-length code; the reserved code falls back to 128-bit.
    function automatic logic [3:0] nr_decode(input logic [1:0] key_len);
        logic [3:0] nr;
        case (key_len)
            KL_128:  nr = NR_128;
            KL_192:  nr = NR_192;
            KL_256:  nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows,
// MixColumns (bypassed on the final round) and AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [0:127] state_i,
    input  logic [0:127] rk_i,
    input  logic         final_i,
    output logic [0:127] state_o
);

    logic [7:0] sb_s [16];
    logic [7:0] sr_s [16];
    logic [7:0] mc_s [16];

    // Round datapath; byte 4c+r is row r of column c.
    always_comb begin
        sb_s    = '{default: 8'h00};
        sr_s    = '{default: 8'h00};
        mc_s    = '{default: 8'h00};
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            sb_s[i] = sbox(state_i[8*i +: 8]);
        end
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_s[4*c + r] = sb_s[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc_s[4*c]     = xtime(sr_s[4*c]) ^ (xtime(sr_s[4*c+1]) ^ sr_s[4*c+1])
                          ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c + 1] = sr_s[4*c] ^ xtime(sr_s[4*c+1])
                          ^ (xtime(sr_s[4*c+2]) ^ sr_s[4*c+2]) ^ sr_s[4*c+3];
            mc_s[4*c + 2] = sr_s[4*c] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2])
                          ^ (xtime(sr_s[4*c+3]) ^ sr_s[4*c+3]);
            mc_s[4*c + 3] = (xtime(sr_s[4*c]) ^ sr_s[4*c]) ^ sr_s[4*c+1]
                          ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            if (final_i) begin
                state_o[8*i +: 8] = sr_s[i] ^ rk_i[8*i +: 8];
            end else begin
                state_o[8*i +: 8] = mc_s[i] ^ rk_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/aes_enc_seq.sv
// Iterative AES encryptor: one shared round unit reused for Nr rounds,
// round keys fetched from an external store with a combinational read port.
module aes_enc_seq
    import aes_pkg::*;
#(
    parameter int NR_MAX = 14,
    parameter int RK_AW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:127]     in_data,
    input  logic [1:0]       key_len,
    output logic [RK_AW-1:0] rk_addr,
    input  logic [0:127]     rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:127]     out_data,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [RK_AW-1:0]   rnd_q, rnd_d;
    logic [RK_AW-1:0]   nr_q, nr_d;
    logic [0:127]       blk_q, blk_d;
    logic [0:127]       out_data_q, out_data_d;
    logic [0:127]       round_out_s;
    logic               final_s;

    // A counter at or beyond the latched round count (or the hardware maximum)
    // is treated as the final round so a corrupted counter still terminates.
    assign final_s = (rnd_q >= nr_q) || (rnd_q >= RK_AW'(NR_MAX));

    aes_round u_round (
        .state_i (blk_q),
        .rk_i    (rk_data),
        .final_i (final_s),
        .state_o (round_out_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_ROUND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (final_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: initial whitening on acceptance, one round per cycle.
    always_comb begin
        rnd_d      = rnd_q;
        nr_d       = nr_q;
        blk_d      = blk_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    blk_d = in_data ^ rk_data;
                    nr_d  = RK_AW'(nr_decode(key_len));
                    rnd_d = RK_AW'(1);
                end else begin
                    blk_d = blk_q;
                end
            end
            ST_ROUND: begin
                blk_d = round_out_s;
                if (final_s) begin
                    out_data_d = round_out_s;
                end else begin
                    rnd_d = rnd_q + RK_AW'(1);
                end
            end
            ST_DONE: begin
                out_data_d = out_data_q;
            end
            default: begin
                rnd_d = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_q      <= '0;
            nr_q       <= '0;
            blk_q      <= '0;
            out_data_q <= '0;
        end else begin
            rnd_q      <= rnd_d;
            nr_q       <= nr_d;
            blk_q      <= blk_d;
            out_data_q <= out_data_d;
        end
    end

    // FSM outputs; in_ready is held low while reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_addr   = '0;
        out_data  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~rst;
            end
            ST_ROUND: begin
                busy    = 1'b1;
                rk_addr = rnd_q;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
